serial_frame_tx: RTL and testbench

//   Parallel-in / serial-out frame transmitter. Serialises one DATA_W-bit word
//   per handshake into: start bit (0), data bits LSB first, stop bit (1).

---
 rtl/serial_frame_tx.sv | 113 +++++++++++
 tb/tb_serial_frame_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-in / serial-out frame transmitter. One DATA_W-bit word is taken
//   per handshake. It goes out as a start bit (0), then the data bits LSB
//   first, then a stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
//   All state updates on the falling edge of clk.
// Ports
//   clk        clock; registers update on negedge
//   reset      asynchronous, active-high reset
//   tx_data    word to send; sampled only on the acceptance edge
//   tx_valid   producer has a word on tx_data
//   tx_ready   block can accept a word (registered, high only in IDLE)
//   tx_serial  serial line, idle high (registered)
//   tx_busy    frame in progress (registered)
//   tx_done    one-cycle pulse when the stop bit has completed
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state;
  logic [BW-1:0]     baud;
  logic [CW-1:0]     bitn;
  logic [DATA_W-1:0] sh;
  logic              wrap;

  // A bit period ends when the baud counter reaches its last count. With
  // CLKS_PER_BIT==1 the counter stays at 0, so every edge is a wrap.
  assign wrap = (baud == BAUD_LAST);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      baud      <= '0;
      bitn      <= '0;
      sh        <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      baud    <= wrap ? '0 : baud + BW'(1);
      case (state)
        S_IDLE: begin
          baud <= '0;
          if (tx_valid) begin
            sh        <= tx_data;
            bitn      <= '0;
            state     <= S_START;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (wrap) begin
            tx_serial <= sh[0];
            sh        <= sh >> 1;
            bitn      <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (wrap) begin
            if (bitn == BIT_LAST) begin
              state     <= S_STOP;
              tx_serial <= 1'b1;
            end else begin
              bitn      <= bitn + CW'(1);
              tx_serial <= sh[0];
              sh        <= sh >> 1;
            end
          end
        end
        S_STOP: begin
          if (wrap) begin
            state    <= S_IDLE;
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          baud      <= '0;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk = 1'b1;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_serial, tx_busy, tx_done;

  logic [4:0] tx_data1;
  logic       tx_valid1;
  logic       tx_ready1, tx_serial1, tx_busy1, tx_done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_serial(tx_serial1), .tx_busy(tx_busy1),
    .tx_done(tx_done1)
  );

  // Expected line level i cycles after acceptance (DATA_W=8, CPB=4).
  function automatic logic exp_line(logic [7:0] w, int i);
    int b;
    b = i / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid1 = 1'b0; tx_data1 = '0;
    #1;
    total++;
    if ({tx_serial, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_state got=%b exp=1100", {tx_serial, tx_ready, tx_busy, tx_done});
    end
    repeat (2) @(posedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int ndone = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    for (int i = 0; i <= 41; i++) begin
      @(posedge clk);
      if (i == 0) tx_valid = 1'b0;
      if (tx_done) ndone++;
      if (i < 40) begin
        total++;
        if (tx_serial !== exp_line(8'hA5, i)) begin
          bad++; $display("FAIL basic_line i=%0d got=%b exp=%b", i, tx_serial, exp_line(8'hA5, i));
        end
      end
      total++;
      if ({tx_done, tx_ready, tx_busy} !== {i == 40, i >= 40, i < 40}) begin
        bad++; $display("FAIL basic_ctl i=%0d got=%b exp=%b", i, {tx_done, tx_ready, tx_busy},
                        {i == 40, i >= 40, i < 40});
      end
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    logic e;
    tx_data = 8'h00; tx_valid = 1'b1;
    for (int i = 0; i <= 82; i++) begin
      @(posedge clk);
      if (i == 40) tx_data = 8'hFF;
      if (i == 41) tx_valid = 1'b0;
      e = (i < 41) ? exp_line(8'h00, i) : exp_line(8'hFF, i - 41);
      if (i >= 36 && i <= 40 && tx_serial === 1'b1) highs++;
      total++;
      if (tx_serial !== e) begin
        bad++; $display("FAIL b2b_line i=%0d got=%b exp=%b", i, tx_serial, e);
      end
      total++;
      if ({tx_ready, tx_done} !== {(i == 40 || i >= 81), (i == 40 || i == 81)}) begin
        bad++; $display("FAIL b2b_ctl i=%0d got=%b exp=%b", i, {tx_ready, tx_done},
                        {(i == 40 || i >= 81), (i == 40 || i == 81)});
      end
    end
    total++;
    if (highs != 5) begin bad++; $display("FAIL b2b_gap got=%0d exp=5", highs); end
  endtask

  task automatic test_ignore_busy();
    int ndone = 0;
    tx_data = 8'h5A; tx_valid = 1'b1;
    for (int i = 0; i <= 55; i++) begin
      @(posedge clk);
      if (i == 0)  tx_valid = 1'b0;
      if (i == 10) begin tx_valid = 1'b1; tx_data = 8'hFF; end
      if (i == 11) tx_valid = 1'b0;
      if (i == 20) tx_data = 8'h00;
      if (tx_done) ndone++;
      total++;
      if (tx_serial !== exp_line(8'h5A, i)) begin
        bad++; $display("FAIL ignore_line i=%0d got=%b exp=%b", i, tx_serial, exp_line(8'h5A, i));
      end
      total++;
      if (tx_busy !== (i < 40)) begin
        bad++; $display("FAIL ignore_busy i=%0d got=%b exp=%b", i, tx_busy, (i < 40));
      end
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_reset_mid();
    tx_data = 8'hC3; tx_valid = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      @(posedge clk);
      if (i == 0) tx_valid = 1'b0;
    end
    total++;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", tx_busy); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({tx_serial, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=1100", {tx_serial, tx_ready, tx_busy, tx_done});
    end
    #1 reset = 1'b0;
    @(posedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    for (int i = 0; i <= 41; i++) begin
      @(posedge clk);
      if (i == 0) tx_valid = 1'b0;
      if (i < 40) begin
        total++;
        if (tx_serial !== exp_line(8'h3C, i)) begin
          bad++; $display("FAIL mid_line i=%0d got=%b exp=%b", i, tx_serial, exp_line(8'h3C, i));
        end
      end
      total++;
      if (tx_done !== (i == 40)) begin
        bad++; $display("FAIL mid_done i=%0d got=%b exp=%b", i, tx_done, (i == 40));
      end
    end
  endtask

  task automatic test_cpb1();
    logic [6:0] exp_seq;
    exp_seq = 7'b1100110;  // bit i = line at sample i: 0,1,1,0,0,1,1
    tx_data1 = 5'h13; tx_valid1 = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk);
      if (i == 0) tx_valid1 = 1'b0;
      if (i < 7) begin
        total++;
        if (tx_serial1 !== exp_seq[i]) begin
          bad++; $display("FAIL cpb1_line i=%0d got=%b exp=%b", i, tx_serial1, exp_seq[i]);
        end
      end
      total++;
      if ({tx_done1, tx_busy1} !== {i == 7, i < 7}) begin
        bad++; $display("FAIL cpb1_ctl i=%0d got=%b exp=%b", i, {tx_done1, tx_busy1}, {i == 7, i < 7});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    repeat (3) @(posedge clk);
    test_back_to_back();
    repeat (3) @(posedge clk);
    test_ignore_busy();
    test_reset_mid();
    test_cpb1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
